// File: rtl/pipeline2_gen_pkg.sv
// Shared constants for the stage-2 decode/register-read block: default widths,
// opcode numbering, ctrl flag layout and the immediate-width derivation.
package params_proc;

    localparam int unsigned DEF_DATA_WIDTH     = 16;
    localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
    localparam int unsigned DEF_NUM_REGS       = 32;
    localparam int unsigned DEF_OPCODE_WIDTH   = 6;
    localparam int unsigned DEF_INSTR_WIDTH    = 32;
    localparam int unsigned DEF_PC_WIDTH       = 16;

    localparam int unsigned OP_LW     = 0;
    localparam int unsigned OP_LW_IMM = 1;
    localparam int unsigned OP_SW     = 2;
    localparam int unsigned OP_ADD    = 3;
    localparam int unsigned OP_SUB    = 4;
    localparam int unsigned OP_MUL    = 5;
    localparam int unsigned OP_DIV    = 6;
    localparam int unsigned OP_AND    = 7;
    localparam int unsigned OP_OR     = 8;
    localparam int unsigned OP_NOT    = 9;
    localparam int unsigned OP_CMP    = 10;
    localparam int unsigned OP_JR     = 11;
    localparam int unsigned OP_JPC    = 12;
    localparam int unsigned OP_BRFL   = 13;
    localparam int unsigned OP_CALL   = 14;
    localparam int unsigned OP_RET    = 15;
    localparam int unsigned OP_NOP    = 16;

    // Bit positions of the flag field in the low end of ctrl.
    localparam int unsigned CTRL_IS_BRANCH = 0;
    localparam int unsigned CTRL_USE_IMM   = 1;
    localparam int unsigned CTRL_MEM_WR    = 2;
    localparam int unsigned CTRL_MEM_RD    = 3;
    localparam int unsigned CTRL_REG_WR    = 4;
    localparam int unsigned CTRL_FLAGS     = 5;

    typedef struct packed {
        logic reg_wr;
        logic mem_rd;
        logic mem_wr;
        logic use_imm;
        logic is_branch;
    } ctrl_flags_t;

    function automatic int unsigned imm_width(input int unsigned instr_w,
                                              input int unsigned opcode_w,
                                              input int unsigned addr_w);
        return instr_w - opcode_w - 2 * addr_w;
    endfunction

endpackage

// File: rtl/pipeline2_regfile.sv
// Register file for stage 2: one synchronous write port, two combinational reads.
// Build with PIPE2_BYPASS_EN defined to forward a same-cycle write to the reads.
module pipeline2_regfile
    import params_proc::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int unsigned NUM_REGS       = DEF_NUM_REGS
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [REG_ADDR_WIDTH-1:0] ra_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rb_addr,
    output logic [DATA_WIDTH-1:0]     ra_data,
    output logic [DATA_WIDTH-1:0]     rb_data
);

    localparam int unsigned DEPTH = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_ok;
    logic                  ra_ok;
    logic                  rb_ok;

    // Addresses at or above NUM_REGS neither write nor read real storage.
    generate
        if (NUM_REGS < DEPTH) begin : g_partial
            assign wr_ok = wr_en && (32'(wr_addr) < NUM_REGS);
            assign ra_ok = 32'(ra_addr) < NUM_REGS;
            assign rb_ok = 32'(rb_addr) < NUM_REGS;
        end else begin : g_full
            assign wr_ok = wr_en;
            assign ra_ok = 1'b1;
            assign rb_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[REG_ADDR_WIDTH'(i)] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        ra_data = ra_ok ? mem[ra_addr] : '0;
        rb_data = rb_ok ? mem[rb_addr] : '0;
`ifdef PIPE2_BYPASS_EN
        if (wr_ok && (wr_addr == ra_addr)) ra_data = wr_data;
        if (wr_ok && (wr_addr == rb_addr)) rb_data = wr_data;
`endif
    end

endmodule

// File: rtl/pipeline2_gen.sv
// Stage 2 decode/register-read with valid/ready, stall, flush and load-use bubbles.
// PIPE2_BYPASS_EN (see pipeline2_regfile) enables write-through operand reads.
module pipeline2_gen
    import params_proc::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int unsigned NUM_REGS       = DEF_NUM_REGS,
    parameter int unsigned OPCODE_WIDTH   = DEF_OPCODE_WIDTH,
    parameter int unsigned INSTR_WIDTH    = DEF_INSTR_WIDTH,
    parameter int unsigned PC_WIDTH       = DEF_PC_WIDTH
) (
    input  logic                             clk_in,
    input  logic                             RST,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             stall,
    input  logic                             flush,
    input  logic [PC_WIDTH-1:0]              pc_in,
    input  logic [INSTR_WIDTH-1:0]           instr,
    input  logic                             reg_en,
    input  logic [REG_ADDR_WIDTH-1:0]        reg_addr,
    input  logic [DATA_WIDTH-1:0]            reg_data,
    output logic [REG_ADDR_WIDTH-1:0]        A_addr,
    output logic [REG_ADDR_WIDTH-1:0]        B_addr,
    output logic signed [DATA_WIDTH-1:0]     A,
    output logic signed [DATA_WIDTH-1:0]     B,
    output logic signed [DATA_WIDTH-1:0]     imm,
    output logic [OPCODE_WIDTH+4:0]          ctrl,
    output logic [PC_WIDTH-1:0]              pc_out,
    output logic                             out_valid,
    output logic                             hazard
);

    localparam int unsigned IMM_WIDTH  = imm_width(INSTR_WIDTH, OPCODE_WIDTH, REG_ADDR_WIDTH);
    localparam int unsigned CTRL_WIDTH = OPCODE_WIDTH + CTRL_FLAGS;

    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] reg_1;
    logic [REG_ADDR_WIDTH-1:0] reg_2;
    logic [IMM_WIDTH-1:0]      imm_field;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [31:0]               op_num;
    ctrl_flags_t               flags;
    logic [DATA_WIDTH-1:0]     rf_a;
    logic [DATA_WIDTH-1:0]     rf_b;

    logic [REG_ADDR_WIDTH-1:0] a_addr_n;
    logic [REG_ADDR_WIDTH-1:0] b_addr_n;
    logic [DATA_WIDTH-1:0]     a_n;
    logic [DATA_WIDTH-1:0]     b_n;
    logic [DATA_WIDTH-1:0]     imm_n;
    logic [CTRL_WIDTH-1:0]     ctrl_n;
    logic [PC_WIDTH-1:0]       pc_n;
    logic                      valid_n;

    // Field split: {imm, REG_2, REG_1, opcode} with opcode in the LSBs.
    assign opcode    = instr[OPCODE_WIDTH-1:0];
    assign reg_1     = instr[OPCODE_WIDTH +: REG_ADDR_WIDTH];
    assign reg_2     = instr[OPCODE_WIDTH+REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign imm_field = instr[INSTR_WIDTH-1 -: IMM_WIDTH];
    assign op_num    = 32'(opcode);

    generate
        if (IMM_WIDTH >= DATA_WIDTH) begin : g_imm_trunc
            assign imm_ext = imm_field[DATA_WIDTH-1:0];
        end else begin : g_imm_sext
            assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm_field[IMM_WIDTH-1]}}, imm_field};
        end
    endgenerate

    pipeline2_regfile #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_REGS       (NUM_REGS)
    ) u_regfile (
        .clk_in  (clk_in),
        .rst     (RST),
        .wr_en   (reg_en),
        .wr_addr (reg_addr),
        .wr_data (reg_data),
        .ra_addr (reg_1),
        .rb_addr (reg_2),
        .ra_data (rf_a),
        .rb_data (rf_b)
    );

    // Control flag decode; NOP and unknown opcodes leave every flag clear.
    always_comb begin
        flags           = '0;
        flags.reg_wr    = op_num inside {OP_LW, OP_LW_IMM, OP_ADD, OP_SUB, OP_MUL,
                                         OP_DIV, OP_AND, OP_OR, OP_NOT};
        flags.mem_rd    = op_num == OP_LW;
        flags.mem_wr    = op_num == OP_SW;
        flags.use_imm   = op_num inside {OP_LW, OP_LW_IMM, OP_SW, OP_JPC, OP_BRFL, OP_CALL};
        flags.is_branch = op_num inside {OP_JR, OP_JPC, OP_BRFL, OP_CALL, OP_RET};
    end

    // A load sitting in the output slot whose target is read by the incoming instr.
    assign hazard   = out_valid && ctrl[CTRL_MEM_RD] && in_valid &&
                      ((A_addr == reg_1) || (A_addr == reg_2));
    assign in_ready = !RST && !stall && !hazard;

    // Next output-register contents; priority flush > stall > hazard > valid.
    always_comb begin
        a_addr_n = A_addr;
        b_addr_n = B_addr;
        a_n      = A;
        b_n      = B;
        imm_n    = imm;
        ctrl_n   = ctrl;
        pc_n     = pc_out;
        valid_n  = out_valid;
        if (flush) begin
            a_addr_n = '0;
            b_addr_n = '0;
            a_n      = '0;
            b_n      = '0;
            imm_n    = '0;
            ctrl_n   = '0;
            pc_n     = '0;
            valid_n  = 1'b0;
        end else if (!stall) begin
            if (in_valid && !hazard) begin
                a_addr_n = reg_1;
                b_addr_n = reg_2;
                a_n      = rf_a;
                b_n      = rf_b;
                imm_n    = imm_ext;
                ctrl_n   = {opcode, flags};
                pc_n     = pc_in;
                valid_n  = 1'b1;
            end else begin
                ctrl_n   = '0;
                valid_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            A_addr    <= '0;
            B_addr    <= '0;
            A         <= '0;
            B         <= '0;
            imm       <= '0;
            ctrl      <= '0;
            pc_out    <= '0;
            out_valid <= 1'b0;
        end else begin
            A_addr    <= a_addr_n;
            B_addr    <= b_addr_n;
            A         <= a_n;
            B         <= b_n;
            imm       <= imm_n;
            ctrl      <= ctrl_n;
            pc_out    <= pc_n;
            out_valid <= valid_n;
        end
    end

endmodule

// File: doc/pipeline2_gen.md
Name: pipeline2_gen

Overview:
- Parametrised successor to the decode/register-read stage (stage 2) of the team's processor pipeline.
- Splits `instr` into opcode, REG_1, REG_2 and imm fields, reads two operands from an internal register file, decodes a control word, and registers everything toward stage 3.
- New over the previous generation: valid/ready handshake, stall, flush, load-use hazard bubble insertion, parametrised widths and depth, optional write-through bypass.

Parameters:
- DATA_WIDTH, 16, operand/register width
- REG_ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, register count (≤ 2^REG_ADDR_WIDTH)
- OPCODE_WIDTH, 6, opcode field width
- INSTR_WIDTH, 32, instruction width; IMM_WIDTH = INSTR_WIDTH-OPCODE_WIDTH-2*REG_ADDR_WIDTH (16 by default)
- PC_WIDTH, 16, program counter width

Ports:
- clk_in  in  1  clock
- RST  in  1  synchronous reset, active-high
- in_valid  in  1  instr/pc_in valid
- in_ready  out  1  stage accepts instr this cycle
- stall  in  1  downstream stall
- flush  in  1  kill in-flight instruction
- pc_in  in  PC_WIDTH  PC of instr
- instr  in  INSTR_WIDTH  {imm, REG_2, REG_1, opcode}, opcode in LSBs
- reg_en  in  1  write-back enable
- reg_addr  in  REG_ADDR_WIDTH  write-back address
- reg_data  in  DATA_WIDTH  write-back data
- A_addr, B_addr  out  REG_ADDR_WIDTH  registered REG_1 / REG_2
- A, B  out  DATA_WIDTH signed  registered operand values
- imm  out  DATA_WIDTH signed  sign-extended imm
- ctrl  out  OPCODE_WIDTH+5  {opcode, reg_wr, mem_rd, mem_wr, use_imm, is_branch}
- pc_out  out  PC_WIDTH  registered pc_in
- out_valid  out  1  outputs hold a real instruction
- hazard  out  1  load-use bubble being inserted this cycle

Behaviour:
- Reset (RST=1 at posedge): all registers 0; all outputs 0, out_valid=0; RST overrides reg_en and every other input. in_ready is combinational: it reads 0 while RST=1 and follows the rule below otherwise.
- Latency: 1 cycle, instr captured at posedge → outputs valid after that edge.
- Register file:
  - Write at posedge when reg_en=1; reg_addr ≥ NUM_REGS is ignored.
  - A reads reg[REG_1] and B reads reg[REG_2]; out-of-range reads return 0.
  - Writes continue during stall, flush and hazard.
- ctrl decode:
  - reg_wr: LW, LW_IMM, ADD, SUB, MUL, DIV, AND, OR, NOT
  - mem_rd: LW
  - mem_wr: SW
  - use_imm: LW, LW_IMM, SW, JPC, BRFL, CALL
  - is_branch: JR, JPC, BRFL, CALL, RET
  - NOP and undefined opcodes: all five flag bits 0
- imm: sign-extended from IMM_WIDTH to DATA_WIDTH; truncated to the low DATA_WIDTH bits if narrower.
- hazard (combinational) = out_valid & ctrl.mem_rd & in_valid & (A_addr==REG_1 | A_addr==REG_2).
- in_ready = !RST & !stall & !hazard.
- Per-cycle priority at posedge, highest first:
  1. RST: clear.
  2. flush: out_valid←0, ctrl←0, other outputs←0; instr consumed and dropped (in_ready=1 unless stall).
  3. stall: every output register holds, including A/B.
  4. hazard: load bubble (out_valid←0, ctrl←0); instr not consumed, re-decoded next cycle with a fresh register read.
  5. in_valid: load decoded instr, out_valid←1.
  6. Otherwise: bubble (out_valid←0, ctrl←0).
- Simultaneous flush+stall: flush wins. Reset asserted mid-stall or mid-hazard: clears everything; the held instruction is lost.

Optional Feature:
- Macro: PIPE2_BYPASS_EN.
- Defined: if reg_en=1 and reg_addr equals REG_1 (or REG_2) in the capture cycle, A (or B) takes reg_data (write-through).
- Undefined: A/B take the pre-write value; the new value is visible from the next capture onward.

Decomposition:
- Shared package (params_proc): opcode constants (LW…NOP), width defaults, ctrl bit indices, IMM_WIDTH derivation.
- Sub-module pipeline2_regfile: NUM_REGS×DATA_WIDTH array, 1 write port, 2 combinational read ports, bypass under PIPE2_BYPASS_EN.
- Decode, hazard logic and the output register stay in pipeline2_gen.

Test Plan:
1. Reset, then write reg3=9 (reg_en=1), next cycle ADD REG_1=3 REG_2=0 pc_in=758 in_valid=1 → A=9, B=0, pc_out=758, out_valid=1, ctrl flags reg_wr=1 and all others 0.
2. LW imm=32767, then CMP imm=-32768 → imm=32767 then -32768; LW ctrl mem_rd=1, use_imm=1.
3. LW REG_1=2, then SUB REG_2=2 → hazard=1, in_ready=0, one bubble (out_valid=0); SUB emerges on the following cycle.
4. stall=1 for 3 cycles with changing instr → outputs and out_valid frozen, in_ready=0; a reg write during the stall lands and is visible after release.
5. flush and stall asserted together with valid ADD → out_valid=0, ctrl=0, in_ready=0.
6. Same-cycle reg_en write reg5=40254 while reading REG_1=5 → A=40254 (as signed 16-bit: -25282) with PIPE2_BYPASS_EN; old value 0 without it.
